fifo_16b_rd: RTL and testbench

- Parameterised 16-bit synchronous FIFO that buffers words written by a producer and presents them to a consumer through a read handshake.
- Storage entries are 16-bit enabled registers, the same storage style as the rest of the cache datapath.
- Sits between the cache-fill/memory-return path (writer) and the cache controller (reader), decoupling a multi-cycle memory from the controller FSM.

---
 rtl/fifo_16b_pkg.sv | 10 +
 rtl/fifo_16b_ptr.sv | 35 +++
 rtl/fifo_16b_rd.sv | 116 +++++++++++
 tb/tb_fifo_16b_rd.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fifo_16b_pkg.sv
// Shared constants for the 16-bit FIFO: data width, default depth and the
// value that storage entries take on reset.
package fifo_16b_pkg;

  localparam int FIFO_DATA_W = 16;
  localparam int FIFO_DEPTH  = 4;

  localparam logic [FIFO_DATA_W-1:0] FIFO_ENTRY_RST = 16'h0000;

endpackage

// File: rtl/fifo_16b_ptr.sv
// Modulo-DEPTH pointer register with increment enable and synchronous
// active-high reset. Used for both the write and the read pointer.
module fifo_16b_ptr #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;

  // Next pointer value: explicit wrap from DEPTH-1 back to 0.
  always_comb begin
    ptr_next = ptr_reg;
    if (en) begin
      if (ptr_reg == LAST) ptr_next = '0;
      else                 ptr_next = ptr_reg + 1'b1;
    end
  end

  // Pointer register; reset returns it to slot 0.
  always_ff @(posedge clk) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_16b_rd.sv
// 16-bit synchronous FIFO with first-word-fall-through read side.
// Writer is the cache-fill / memory-return path, reader is the cache
// controller. Full/empty are decoded from the occupancy count.
// Optional sticky overflow/underflow flag: define FIFO_16B_ERR_FLAG_EN to
// add the err output.
module fifo_16b_rd
  import fifo_16b_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [FIFO_DATA_W-1:0] wr_data,
  output logic                   full,
  input  logic                   rd_en,
  output logic [FIFO_DATA_W-1:0] rd_data,
  output logic                   empty,
`ifdef FIFO_16B_ERR_FLAG_EN
  output logic                   err,
`endif
  output logic [PTR_W:0]         count
);

  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count_reg;
  logic [PTR_W:0]         count_next;
  logic                   rd_acc;
  logic                   wr_acc;
  logic [FIFO_DATA_W-1:0] entry_word [DEPTH];

  // Status flags come from the count only, so a full FIFO and an empty one
  // (which share equal pointers) are never confused.
  assign empty = (count_reg == '0);
  assign full  = (count_reg == COUNT_FULL);
  assign count = count_reg;

  // Accept rules: a pop frees a slot in the same cycle, so a write to a full
  // FIFO is only accepted alongside a pop.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  fifo_16b_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (wr_acc),
    .ptr (wr_ptr)
  );

  fifo_16b_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (rd_acc),
    .ptr (rd_ptr)
  );

  // One enabled 16-bit register per entry, loaded when the write pointer
  // addresses it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [FIFO_DATA_W-1:0] word_reg;
      logic                   load;

      assign load = wr_acc & (wr_ptr == PTR_W'(gi));

      // Entry register with synchronous clear.
      always_ff @(posedge clk) begin
        if (rst)       word_reg <= FIFO_ENTRY_RST;
        else if (load) word_reg <= wr_data;
      end

      assign entry_word[gi] = word_reg;
    end
  endgenerate

  // Head word falls through combinationally; forced to zero while empty so
  // stale entry contents are never exposed.
  always_comb begin
    rd_data = FIFO_ENTRY_RST;
    if (!empty) rd_data = entry_word[rd_ptr];
  end

  // Occupancy: net change of +1 / -1 / 0 depending on which sides accepted.
  always_comb begin
    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) count_reg <= '0;
    else     count_reg <= count_next;
  end

`ifdef FIFO_16B_ERR_FLAG_EN
  logic err_reg;

  // Sticky error: set by a dropped write or a read of an empty FIFO,
  // cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) err_reg <= 1'b0;
    else     err_reg <= err_reg | (wr_en & ~wr_acc) | (rd_en & empty);
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_fifo_16b_rd.sv
// Directed self-checking bench for fifo_16b_rd: reset, fill/drain, overflow,
// simultaneous read/write at full, wrap-around, and reset mid-stream.
module tb_fifo_16b_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        empty;
  logic [2:0]  count;
`ifdef FIFO_16B_ERR_FLAG_EN
  logic        err;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  fifo_16b_rd #(.DEPTH(4), .PTR_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
`ifdef FIFO_16B_ERR_FLAG_EN
    .err     (err),
`endif
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) begin
      pass_cnt++;
      $display("check %s: observed %h expected %h ok", tag, obs, exp_v);
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] words [4];
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 16'h0;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;

    // Reset then idle
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_empty", 16'(empty), 16'd1);
    chk("idle_full", 16'(full), 16'd0);
    chk("idle_count", 16'(count), 16'd0);
    chk("idle_rd_data", rd_data, 16'h0000);

    // Fill
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = words[i];
      step();
      chk($sformatf("fill_count_%0d", i), 16'(count), 16'(i + 1));
    end
    wr_en = 1'b0;
    chk("fill_full", 16'(full), 16'd1);
    chk("fill_head", rd_data, 16'h1111);

    // Overflow: write while full without a pop is dropped
    wr_en = 1'b1; wr_data = 16'h5555;
    step();
    wr_en = 1'b0;
    chk("ovf_count", 16'(count), 16'd4);
    chk("ovf_head", rd_data, 16'h1111);
`ifdef FIFO_16B_ERR_FLAG_EN
    chk("ovf_err", 16'(err), 16'd1);
`endif

    // Drain in order; 5555 must not appear
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_%0d", i), rd_data, words[i]);
      step();
    end
    rd_en = 1'b0;
    chk("drain_empty", 16'(empty), 16'd1);
    chk("drain_count", 16'(count), 16'd0);
    chk("drain_rd_data", rd_data, 16'h0000);

    // Simultaneous read/write at full
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = words[i];
      step();
    end
    chk("rw_pre_full", 16'(full), 16'd1);
    wr_en = 1'b1; wr_data = 16'hAAAA; rd_en = 1'b1;
    step();
    wr_en = 1'b0;
    chk("rw_count", 16'(count), 16'd4);
    words[0] = 16'h2222; words[1] = 16'h3333; words[2] = 16'h4444; words[3] = 16'hAAAA;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rw_drain_%0d", i), rd_data, words[i]);
      step();
    end
    rd_en = 1'b0;
    chk("rw_empty", 16'(empty), 16'd1);

    // Wrap-around with read-while-empty on each write cycle
    for (int i = 1; i <= 10; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'(i);
      step();
      chk($sformatf("wrap_cnt_%0d", i), 16'(count), 16'd1);
      chk($sformatf("wrap_data_%0d", i), rd_data, 16'(i));
      wr_en = 1'b0; rd_en = 1'b1;
      step();
      chk($sformatf("wrap_empty_%0d", i), 16'(empty), 16'd1);
    end
    rd_en = 1'b0;
    chk("wrap_final_count", 16'(count), 16'd0);

    // Reset mid-operation with simultaneous write and read
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 16'h0B01 + 16'(i);
      step();
    end
    wr_en = 1'b0;
    chk("mid_pre_count", 16'(count), 16'd3);
    chk("mid_pre_head", rd_data, 16'h0B01);
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'hDEAD;
    step();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("mid_count", 16'(count), 16'd0);
    chk("mid_empty", 16'(empty), 16'd1);
    chk("mid_full", 16'(full), 16'd0);
    chk("mid_rd_data", rd_data, 16'h0000);
`ifdef FIFO_16B_ERR_FLAG_EN
    chk("mid_err", 16'(err), 16'd0);
`endif
    step();
    chk("post_count", 16'(count), 16'd0);
    chk("post_rd_data", rd_data, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
